// File: rtl/id_ex_stage_register.sv
// ID/EX pipeline register: payload capture, bubble insertion, EX hold.
// Optional ID_EX_BUBBLE_COUNT_EN adds a wrapping 32-bit bubbleCount port.
module id_ex_stage_register (
    input  logic        clk,
    input  logic        reset,
    input  logic        stallAndFlush,
    input  logic        holdInEX,
    input  logic [31:0] pcInID,
    input  logic [31:0] instrInID,
    input  logic [31:0] rsValueInID,
    input  logic [31:0] rtValueInID,
    input  logic [31:0] extImmInID,
    input  logic [4:0]  command2521InID,
    input  logic [4:0]  command2016InID,
    input  logic [4:0]  regFinalDstInID,
    input  logic        regWriteEnabledInID,
    input  logic        regConditionMoveInID,
    input  logic [2:0]  tNewInID,
    output logic [31:0] pcInEX,
    output logic [31:0] instrInEX,
    output logic [31:0] rsValueInEX,
    output logic [31:0] rtValueInEX,
    output logic [31:0] extImmInEX,
    output logic [4:0]  currentCommand2521InEX,
    output logic [4:0]  currentCommand2016InEX,
    output logic [4:0]  regFinalDstInEX,
    output logic        regWriteEnabledInEX,
    output logic        regConditionMoveInEX,
    output logic [2:0]  tNewInEX,
    output logic        validInEX
`ifdef ID_EX_BUBBLE_COUNT_EN
    ,
    output logic [31:0] bubbleCount
`endif
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] rsv;
        logic [31:0] rtv;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dst;
        logic        we;
        logic        cm;
        logic [2:0]  tnew;
        logic        valid;
    } ex_t;

    ex_t ex_q, ex_d;
    logic load_bubble;

    assign load_bubble = !holdInEX && stallAndFlush;

    always_comb begin
        ex_d = ex_q;
        if (!holdInEX) begin
            if (stallAndFlush) begin
                // all-zero bubble: we/cm low so it never forwards
                ex_d = '0;
            end else begin
                ex_d.pc    = pcInID;
                ex_d.instr = instrInID;
                ex_d.rsv   = rsValueInID;
                ex_d.rtv   = rtValueInID;
                ex_d.imm   = extImmInID;
                ex_d.rs    = command2521InID;
                ex_d.rt    = command2016InID;
                ex_d.dst   = regFinalDstInID;
                ex_d.we    = regWriteEnabledInID;
                ex_d.cm    = regConditionMoveInID;
                ex_d.tnew  = (tNewInID != 3'd0) ? tNewInID - 3'd1 : 3'd0;
                ex_d.valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign pcInEX                 = ex_q.pc;
    assign instrInEX              = ex_q.instr;
    assign rsValueInEX            = ex_q.rsv;
    assign rtValueInEX            = ex_q.rtv;
    assign extImmInEX             = ex_q.imm;
    assign currentCommand2521InEX = ex_q.rs;
    assign currentCommand2016InEX = ex_q.rt;
    assign regFinalDstInEX        = ex_q.dst;
    assign regWriteEnabledInEX    = ex_q.we;
    assign regConditionMoveInEX   = ex_q.cm;
    assign tNewInEX               = ex_q.tnew;
    assign validInEX              = ex_q.valid;

`ifdef ID_EX_BUBBLE_COUNT_EN
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (load_bubble) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bubbleCount = bubble_cnt_q;
`else
    logic unused_bubble;
    assign unused_bubble = load_bubble;
`endif

endmodule

// File: tb/tb_id_ex_stage_register.sv
// Scoreboard bench for id_ex_stage_register: driver queues hand-computed
// expectations, a monitor compares them one cycle later.
module tb_id_ex_stage_register;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] rsv;
        logic [31:0] rtv;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dst;
        logic        we;
        logic        cm;
        logic [2:0]  tnew;
    } id_t;

    typedef struct packed {
        id_t         p;
        logic        valid;
        logic [31:0] bc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stallAndFlush = 1'b0;
    logic        holdInEX = 1'b0;
    id_t         in_s = '0;
    logic [31:0] pcInEX, instrInEX, rsValueInEX, rtValueInEX, extImmInEX;
    logic [4:0]  c2521, c2016, dstEX;
    logic        weEX, cmEX, validInEX;
    logic [2:0]  tNewInEX;
`ifdef ID_EX_BUBBLE_COUNT_EN
    logic [31:0] bubbleCount;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    string nm_q[$];
    exp_t last;

    always #5 clk = ~clk;

    id_ex_stage_register dut (
        .clk                    (clk),
        .reset                  (reset),
        .stallAndFlush          (stallAndFlush),
        .holdInEX               (holdInEX),
        .pcInID                 (in_s.pc),
        .instrInID              (in_s.instr),
        .rsValueInID            (in_s.rsv),
        .rtValueInID            (in_s.rtv),
        .extImmInID             (in_s.imm),
        .command2521InID        (in_s.rs),
        .command2016InID        (in_s.rt),
        .regFinalDstInID        (in_s.dst),
        .regWriteEnabledInID    (in_s.we),
        .regConditionMoveInID   (in_s.cm),
        .tNewInID               (in_s.tnew),
        .pcInEX                 (pcInEX),
        .instrInEX              (instrInEX),
        .rsValueInEX            (rsValueInEX),
        .rtValueInEX            (rtValueInEX),
        .extImmInEX             (extImmInEX),
        .currentCommand2521InEX (c2521),
        .currentCommand2016InEX (c2016),
        .regFinalDstInEX        (dstEX),
        .regWriteEnabledInEX    (weEX),
        .regConditionMoveInEX   (cmEX),
        .tNewInEX               (tNewInEX),
        .validInEX              (validInEX)
`ifdef ID_EX_BUBBLE_COUNT_EN
        ,
        .bubbleCount            (bubbleCount)
`endif
    );

    // Monitor: one registered output per edge, sampled 1 time unit after it.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t  e;
            string n;
            id_t   a;
            e = exp_q.pop_front();
            n = nm_q.pop_front();
            a = '{pcInEX, instrInEX, rsValueInEX, rtValueInEX, extImmInEX,
                  c2521, c2016, dstEX, weEX, cmEX, tNewInEX};
            checks++;
            if (a !== e.p || validInEX !== e.valid) begin
                errors++;
                $display("FAIL %s: got pc=%h instr=%h dst=%0d we=%b cm=%b tnew=%0d valid=%b rs=%0d rt=%0d, want pc=%h instr=%h dst=%0d we=%b cm=%b tnew=%0d valid=%b rs=%0d rt=%0d",
                         n, a.pc, a.instr, a.dst, a.we, a.cm, a.tnew, validInEX, a.rs, a.rt,
                         e.p.pc, e.p.instr, e.p.dst, e.p.we, e.p.cm, e.p.tnew, e.valid, e.p.rs, e.p.rt);
            end
`ifdef ID_EX_BUBBLE_COUNT_EN
            checks++;
            if (bubbleCount !== e.bc) begin
                errors++;
                $display("FAIL %s bubbleCount: got %h want %h", n, bubbleCount, e.bc);
            end
`endif
        end
    end

    function automatic exp_t mk_load(input id_t in, input logic [2:0] tn,
                                     input logic [31:0] bc);
        exp_t e;
        e.p      = in;
        e.p.tnew = tn;
        e.valid  = 1'b1;
        e.bc     = bc;
        return e;
    endfunction

    function automatic exp_t mk_bub(input logic [31:0] bc);
        exp_t e;
        e    = '0;
        e.bc = bc;
        return e;
    endfunction

    task automatic cyc(input string nm, input logic r, input logic sf,
                       input logic hd, input id_t in, input exp_t e);
        @(posedge clk);
        #2;
        reset         = r;
        stallAndFlush = sf;
        holdInEX      = hd;
        in_s          = in;
        exp_q.push_back(e);
        nm_q.push_back(nm);
        last = e;
    endtask

    id_t junk, addu, lw, sw, lw2, slt, late;

    initial begin
        junk = '{32'hDEADBEEF, 32'h12345678, 32'h11111111, 32'h22222222,
                 32'h33333333, 5'd3, 5'd4, 5'd9, 1'b1, 1'b1, 3'd5};
        addu = '{32'h00003000, 32'h00430821, 32'h00000005, 32'h00000007,
                 32'h00000821, 5'd2, 5'd3, 5'd8, 1'b1, 1'b0, 3'd2};
        lw   = '{32'h00003004, 32'h8C080004, 32'h00001000, 32'h0,
                 32'h00000004, 5'd0, 5'd8, 5'd8, 1'b1, 1'b0, 3'd3};
        sw   = '{32'h00003008, 32'hAC080004, 32'h00001000, 32'hCAFEF00D,
                 32'h00000004, 5'd0, 5'd8, 5'd0, 1'b0, 1'b0, 3'd0};
        lw2  = '{32'h0000300C, 32'h8C080004, 32'h00002000, 32'h0,
                 32'h00000004, 5'd0, 5'd8, 5'd8, 1'b1, 1'b1, 3'd3};
        slt  = '{32'h00003010, 32'h0109502A, 32'hFFFFFFFF, 32'h00000001,
                 32'h0000502A, 5'd8, 5'd9, 5'd10, 1'b1, 1'b0, 3'd1};
        late = '{32'h00003014, 32'h00000000, 32'h0, 32'h0,
                 32'h0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 3'd7};

        cyc("reset1", 1, 0, 0, junk, mk_bub(0));
        cyc("reset2", 1, 1, 0, junk, mk_bub(0));
        cyc("load_addu", 0, 0, 0, addu, mk_load(addu, 3'd1, 0));
        cyc("stall1", 0, 1, 0, lw, mk_bub(1));
        cyc("stall2", 0, 1, 0, lw, mk_bub(2));
        cyc("load_lw", 0, 0, 0, lw, mk_load(lw, 3'd2, 2));
        cyc("load_sw_sat", 0, 0, 0, sw, mk_load(sw, 3'd0, 2));
        cyc("load_lw2", 0, 0, 0, lw2, mk_load(lw2, 3'd2, 2));
        cyc("hold1", 0, 1, 1, junk, last);
        cyc("hold2", 0, 1, 1, junk, last);
        cyc("hold3", 0, 1, 1, slt, last);
        cyc("release", 0, 0, 0, slt, mk_load(slt, 3'd0, 2));
        cyc("tnew7", 0, 0, 0, late, mk_load(late, 3'd6, 2));
`ifdef ID_EX_BUBBLE_COUNT_EN
        @(posedge clk);
        #2;
        force dut.bubble_cnt_q = 32'hFFFFFFFF;
        #1;
        release dut.bubble_cnt_q;
        stallAndFlush = 1'b1;
        exp_q.push_back(mk_bub(32'h0));
        nm_q.push_back("wrap");
`else
        cyc("flush", 0, 1, 0, late, mk_bub(0));
`endif
        cyc("flush_b", 0, 1, 0, late, mk_bub(1));
        cyc("reset_in_stall", 1, 1, 0, late, mk_bub(0));
        cyc("first_after_rst", 0, 0, 0, addu, mk_load(addu, 3'd1, 0));
        cyc("idle_bubble", 0, 1, 0, junk, mk_bub(1));

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
            #3;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
